// File: rtl/mul8_share_ctrl.sv
// mul8_share_ctrl
// ---------------
// Sequential 8x8 unsigned multiplier controller. One 4x4 array multiplier
// core is reused over four cycles to form the partial products
//    b*d, (a*d)<<4, (b*c)<<4, (a*c)<<8
// where a/b are the high/low nibbles of operand A and c/d are the high/low
// nibbles of operand B. Two requesters share the unit through round-robin
// arbitration. Each result returns with the requester's tag and index.
//
// Optional feature (macro MUL8_ZERO_BYPASS_EN):
//    When defined, an accepted operation with A==0 or B==0 skips P0-P3. It
//    goes straight from IDLE to DONE with a zero product. When undefined,
//    zero operands take the normal four-step sequence.
//
// Ports:
//    clk_i          clock, all state on the rising edge
//    rst_i          asynchronous active-high reset
//    req0_valid_i   requester 0 has an operation
//    req0_ready_o   requester 0 operation accepted this cycle (combinational)
//    req0_a_i       requester 0 operand A
//    req0_b_i       requester 0 operand B
//    req0_tag_i     requester 0 tag
//    req1_*         same set of signals for requester 1
//    res_valid_o    result available
//    res_ready_i    consumer accepts result
//    res_data_o     16-bit unsigned product A*B
//    res_tag_o      tag of the request that produced the result
//    res_src_o      index of the requester that owned the operation
//    busy_o         high in every state except IDLE

module mul8_share_ctrl #(
   parameter int unsigned TAG_W = 4
) (
   input  logic             clk_i,
   input  logic             rst_i,

   input  logic             req0_valid_i,
   output logic             req0_ready_o,
   input  logic [7:0]       req0_a_i,
   input  logic [7:0]       req0_b_i,
   input  logic [TAG_W-1:0] req0_tag_i,

   input  logic             req1_valid_i,
   output logic             req1_ready_o,
   input  logic [7:0]       req1_a_i,
   input  logic [7:0]       req1_b_i,
   input  logic [TAG_W-1:0] req1_tag_i,

   output logic             res_valid_o,
   input  logic             res_ready_i,
   output logic [15:0]      res_data_o,
   output logic [TAG_W-1:0] res_tag_o,
   output logic             res_src_o,

   output logic             busy_o
);

   typedef enum logic [2:0] {
      StIdle,
      StP0,
      StP1,
      StP2,
      StP3,
      StDone
   } state_e;

   state_e             state_q;
   logic [7:0]         op_a_q;
   logic [7:0]         op_b_q;
   logic [TAG_W-1:0]   tag_q;
   logic               src_q;
   logic [15:0]        acc_q;
   logic               last_grant_q;

   logic               res_valid_q;
   logic [15:0]        res_data_q;
   logic [TAG_W-1:0]   res_tag_q;
   logic               res_src_q;

   // -------------------------------------------------------------------------
   // Round-robin arbitration, evaluated only while idle
   // -------------------------------------------------------------------------
   logic               grant0;
   logic               grant1;
   logic               idle;
   logic               accept;
   logic [7:0]         sel_a;
   logic [7:0]         sel_b;
   logic [TAG_W-1:0]   sel_tag;

   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (req0_valid_i && req1_valid_i) begin
         // On contention the requester that was not served last wins.
         grant0 = last_grant_q;
         grant1 = ~last_grant_q;
      end else begin
         grant0 = req0_valid_i;
         grant1 = req1_valid_i;
      end
   end

   // Ready is gated by reset so both readys read 0 while rst_i is high.
   assign idle         = (state_q == StIdle) && !rst_i;
   assign req0_ready_o = idle && grant0;
   assign req1_ready_o = idle && grant1;
   assign accept       = req0_ready_o || req1_ready_o;

   assign sel_a   = grant1 ? req1_a_i   : req0_a_i;
   assign sel_b   = grant1 ? req1_b_i   : req0_b_i;
   assign sel_tag = grant1 ? req1_tag_i : req0_tag_i;

   // -------------------------------------------------------------------------
   // Shared 4x4 core: the state selects its operand nibbles
   // -------------------------------------------------------------------------
   logic [3:0]         core_x;
   logic [3:0]         core_y;
   logic [7:0]         core_p;
   logic [15:0]        pp_aligned;
   logic [15:0]        acc_sum;

   always_comb begin
      core_x = 4'h0;
      core_y = 4'h0;
      unique case (state_q)
         StP0: begin core_x = op_a_q[3:0]; core_y = op_b_q[3:0]; end // b*d
         StP1: begin core_x = op_a_q[7:4]; core_y = op_b_q[3:0]; end // a*d
         StP2: begin core_x = op_a_q[3:0]; core_y = op_b_q[7:4]; end // b*c
         StP3: begin core_x = op_a_q[7:4]; core_y = op_b_q[7:4]; end // a*c
         default: begin core_x = 4'h0; core_y = 4'h0; end
      endcase
   end

   // Array multiplier: one shifted row of core_x per set bit of core_y.
   always_comb begin
      core_p = 8'h00;
      for (int i = 0; i < 4; i++) begin
         if (core_y[i]) begin
            core_p = core_p + ({4'h0, core_x} << i);
         end
      end
   end

   always_comb begin
      pp_aligned = 16'h0000;
      unique case (state_q)
         StP0:        pp_aligned = {8'h00, core_p};
         StP1, StP2:  pp_aligned = {4'h0, core_p, 4'h0};
         StP3:        pp_aligned = {core_p, 8'h00};
         default:     pp_aligned = 16'h0000;
      endcase
   end

   // The final sum is at most 16'hFE01, so truncating to 16 bits is lossless.
   assign acc_sum = acc_q + pp_aligned;

   // -------------------------------------------------------------------------
   // Control FSM with registered result outputs
   // -------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         op_a_q       <= 8'h00;
         op_b_q       <= 8'h00;
         tag_q        <= '0;
         src_q        <= 1'b0;
         acc_q        <= 16'h0000;
         last_grant_q <= 1'b1;
         res_valid_q  <= 1'b0;
         res_data_q   <= 16'h0000;
         res_tag_q    <= '0;
         res_src_q    <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (accept) begin
                  op_a_q       <= sel_a;
                  op_b_q       <= sel_b;
                  tag_q        <= sel_tag;
                  src_q        <= grant1;
                  last_grant_q <= grant1;
                  acc_q        <= 16'h0000;
`ifdef MUL8_ZERO_BYPASS_EN
                  if ((sel_a == 8'h00) || (sel_b == 8'h00)) begin
                     state_q     <= StDone;
                     res_valid_q <= 1'b1;
                     res_data_q  <= 16'h0000;
                     res_tag_q   <= sel_tag;
                     res_src_q   <= grant1;
                  end else begin
                     state_q <= StP0;
                  end
`else
                  state_q <= StP0;
`endif
               end
            end
            StP0: begin
               acc_q   <= acc_sum;
               state_q <= StP1;
            end
            StP1: begin
               acc_q   <= acc_sum;
               state_q <= StP2;
            end
            StP2: begin
               acc_q   <= acc_sum;
               state_q <= StP3;
            end
            StP3: begin
               acc_q       <= acc_sum;
               res_data_q  <= acc_sum;
               res_tag_q   <= tag_q;
               res_src_q   <= src_q;
               res_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               // Result registers are held until the consumer takes them.
               if (res_ready_i) begin
                  res_valid_q <= 1'b0;
                  state_q     <= StIdle;
               end
            end
            default: begin
               res_valid_q <= 1'b0;
               state_q     <= StIdle;
            end
         endcase
      end
   end

   assign res_valid_o = res_valid_q;
   assign res_data_o  = res_data_q;
   assign res_tag_o   = res_tag_q;
   assign res_src_o   = res_src_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_mul8_share_ctrl.sv
// Directed testbench for mul8_share_ctrl. Edge T is the clock edge that
// starts the cycle where ready is high. The capture edge is T+1. A normal
// result is visible after T+5. A zero-bypass result is visible after T+1.

module tb_mul8_share_ctrl;

   localparam int unsigned TAG_W = 4;
`ifdef MUL8_ZERO_BYPASS_EN
   localparam int ZLAT = 1;
`else
   localparam int ZLAT = 5;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             req0_valid, req0_ready;
   logic [7:0]       req0_a, req0_b;
   logic [TAG_W-1:0] req0_tag;
   logic             req1_valid, req1_ready;
   logic [7:0]       req1_a, req1_b;
   logic [TAG_W-1:0] req1_tag;
   logic             res_valid, res_ready;
   logic [15:0]      res_data;
   logic [TAG_W-1:0] res_tag;
   logic             res_src;
   logic             busy;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   mul8_share_ctrl #(.TAG_W(TAG_W)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .req0_valid_i (req0_valid),
      .req0_ready_o (req0_ready),
      .req0_a_i     (req0_a),
      .req0_b_i     (req0_b),
      .req0_tag_i   (req0_tag),
      .req1_valid_i (req1_valid),
      .req1_ready_o (req1_ready),
      .req1_a_i     (req1_a),
      .req1_b_i     (req1_b),
      .req1_tag_i   (req1_tag),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_data_o   (res_data),
      .res_tag_o    (res_tag),
      .res_src_o    (res_src),
      .busy_o       (busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Stimulus helper: issue one operation, wait for acceptance and result.
   // lat counts edges from T to the first sample with res_valid high
   // (-1 on timeout). other_rdy records any ready seen on the other requester.
   task automatic do_op(input bit src, input logic [7:0] a, input logic [7:0] b,
                        input logic [TAG_W-1:0] tag, output bit got, output int lat,
                        output logic [15:0] d, output logic [TAG_W-1:0] t,
                        output logic s, output bit other_rdy);
      int cnt;
      got = 1'b0;
      other_rdy = 1'b0;
      if (src) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_tag = tag;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_tag = tag;
      end
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (src ? req0_ready : req1_ready) other_rdy = 1'b1;
         if (src ? req1_ready : req0_ready) got = 1'b1;
         else tick();
      end
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      cnt = 1;
      while (!res_valid && cnt < 30) begin
         if (src ? req0_ready : req1_ready) other_rdy = 1'b1;
         tick();
         cnt++;
      end
      lat = res_valid ? cnt : -1;
      d = res_data;
      t = res_tag;
      s = res_src;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      req0_valid = 1'b1; req1_valid = 1'b1;
      req0_a = 8'h11; req0_b = 8'h22; req0_tag = 4'h1;
      req1_a = 8'h33; req1_b = 8'h44; req1_tag = 4'h2;
      res_ready = 1'b0;
      #3;
      n_total++;
      if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_total++;
      if (res_valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_res_valid: got %b want 0", res_valid);
      end
      n_total++;
      if (res_data !== 16'h0000) begin
         n_bad++; $display("FAIL rst_res_data: got %h want 0000", res_data);
      end
      n_total++;
      if (res_tag !== 4'h0 || res_src !== 1'b0) begin
         n_bad++; $display("FAIL rst_tag_src: got %h/%b want 0/0", res_tag, res_src);
      end
      tick();
      n_total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_bad++; $display("FAIL rst_readys: got %b%b want 00", req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_full_scale();
      bit got, oth; int lat; logic [15:0] d; logic [TAG_W-1:0] t; logic s;
      res_ready = 1'b1;
      do_op(1'b0, 8'hFF, 8'hFF, 4'h5, got, lat, d, t, s, oth);
      n_total++;
      if (!got) begin n_bad++; $display("FAIL fs_grant: got 0 want 1"); end
      n_total++;
      if (lat != 5) begin n_bad++; $display("FAIL fs_latency: got %0d want 5", lat); end
      n_total++;
      if (d !== 16'hFE01) begin n_bad++; $display("FAIL fs_data: got %h want fe01", d); end
      n_total++;
      if (t !== 4'h5 || s !== 1'b0) begin
         n_bad++; $display("FAIL fs_tag_src: got %h/%b want 5/0", t, s);
      end
      tick();
      n_total++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL fs_done_1cyc: got valid=%b busy=%b want 0 0", res_valid, busy);
      end
   endtask

   task automatic test_zero_operand();
      bit got, oth; int lat; logic [15:0] d; logic [TAG_W-1:0] t; logic s;
      res_ready = 1'b1;
      do_op(1'b0, 8'h00, 8'h5A, 4'h3, got, lat, d, t, s, oth);
      n_total++;
      if (lat != ZLAT) begin n_bad++; $display("FAIL zero_latency: got %0d want %0d", lat, ZLAT); end
      n_total++;
      if (d !== 16'h0000) begin n_bad++; $display("FAIL zero_data: got %h want 0000", d); end
      n_total++;
      if (t !== 4'h3 || s !== 1'b0) begin
         n_bad++; $display("FAIL zero_tag_src: got %h/%b want 3/0", t, s);
      end
      tick();
      n_total++;
      if (res_valid !== 1'b0) begin n_bad++; $display("FAIL zero_drop: got %b want 0", res_valid); end
   endtask

   task automatic test_req1_tag();
      bit got, oth; int lat; logic [15:0] d; logic [TAG_W-1:0] t; logic s;
      res_ready = 1'b1;
      do_op(1'b1, 8'h12, 8'h34, 4'hA, got, lat, d, t, s, oth);
      n_total++;
      if (!got) begin n_bad++; $display("FAIL r1_grant: got 0 want 1"); end
      n_total++;
      if (lat != 5) begin n_bad++; $display("FAIL r1_latency: got %0d want 5", lat); end
      n_total++;
      if (d !== 16'h03A8) begin n_bad++; $display("FAIL r1_data: got %h want 03a8", d); end
      n_total++;
      if (t !== 4'hA || s !== 1'b1) begin
         n_bad++; $display("FAIL r1_tag_src: got %h/%b want a/1", t, s);
      end
      n_total++;
      if (oth) begin n_bad++; $display("FAIL r1_req0_ready: got 1 want 0"); end
      tick();
   endtask

   task automatic test_back_to_back();
      bit seen; logic g; int cnt;
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'h07; req0_b = 8'h09; req0_tag = 4'h6;
      req1_valid = 1'b1; req1_a = 8'h80; req1_b = 8'h02; req1_tag = 4'h9;
      for (int k = 0; k < 4; k++) begin
         seen = 1'b0; g = 1'b0;
         for (int i = 0; i < 20 && !seen; i++) begin
            #1;
            if (req0_ready || req1_ready) begin seen = 1'b1; g = req1_ready; end
            else tick();
         end
         n_total++;
         if (!seen || req0_ready === req1_ready || g !== k[0]) begin
            n_bad++;
            $display("FAIL b2b_grant%0d: got r0=%b r1=%b want src %0d", k, req0_ready,
                     req1_ready, k[0]);
         end
         tick();
         cnt = 0;
         while (!res_valid && cnt < 30) begin tick(); cnt++; end
         n_total++;
         if (res_valid !== 1'b1 || res_src !== k[0]) begin
            n_bad++;
            $display("FAIL b2b_src%0d: got valid=%b src=%b want 1 %0d", k, res_valid, res_src, k[0]);
         end
         n_total++;
         if (res_data !== (k[0] ? 16'h0100 : 16'h003F)) begin
            n_bad++;
            $display("FAIL b2b_data%0d: got %h want %h", k, res_data,
                     (k[0] ? 16'h0100 : 16'h003F));
         end
         n_total++;
         if (res_tag !== (k[0] ? 4'h9 : 4'h6)) begin
            n_bad++; $display("FAIL b2b_tag%0d: got %h want %h", k, res_tag, (k[0] ? 4'h9 : 4'h6));
         end
         tick();
         if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      end
   endtask

   task automatic test_backpressure();
      bit got, oth; int lat; logic [15:0] d; logic [TAG_W-1:0] t; logic s;
      res_ready = 1'b0;
      do_op(1'b0, 8'h0F, 8'h10, 4'h7, got, lat, d, t, s, oth);
      n_total++;
      if (lat != 5 || d !== 16'h00F0) begin
         n_bad++; $display("FAIL bp_first: got lat=%0d data=%h want 5 00f0", lat, d);
      end
      req1_valid = 1'b1; req1_a = 8'h03; req1_b = 8'h03; req1_tag = 4'hC;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_total++;
         if (res_valid !== 1'b1 || res_data !== 16'h00F0 || res_tag !== 4'h7) begin
            n_bad++;
            $display("FAIL bp_hold%0d: got v=%b d=%h t=%h want 1 00f0 7", i, res_valid, res_data,
                     res_tag);
         end
         n_total++;
         if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_busy%0d: got busy=%b rdy=%b%b want 1 00", i, busy, req0_ready,
                     req1_ready);
         end
      end
      res_ready = 1'b1;
      tick();
      n_total++;
      if (res_valid !== 1'b0 || busy !== 1'b0) begin
         n_bad++; $display("FAIL bp_release: got v=%b busy=%b want 0 0", res_valid, busy);
      end
      n_total++;
      if (req1_ready !== 1'b1) begin n_bad++; $display("FAIL bp_wait_idle: got %b want 1", req1_ready); end
      // Drop valid before the edge: withdrawing an unaccepted request is legal.
      req1_valid = 1'b0;
      tick();
   endtask

   task automatic test_reset_midop();
      bit got;
      res_ready = 1'b1;
      req0_valid = 1'b1; req0_a = 8'h12; req0_b = 8'h34; req0_tag = 4'hE;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (req0_ready) got = 1'b1; else tick();
      end
      tick();          // capture: P0
      req0_valid = 1'b0;
      tick();          // P1
      tick();          // P2
      n_total++;
      if (!got || busy !== 1'b1) begin
         n_bad++; $display("FAIL mr_busy_pre: got grant=%b busy=%b want 1 1", got, busy);
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      n_total++;
      if (busy !== 1'b0 || res_valid !== 1'b0) begin
         n_bad++; $display("FAIL mr_async: got busy=%b v=%b want 0 0", busy, res_valid);
      end
      n_total++;
      if (res_data !== 16'h0000 || res_tag !== 4'h0 || res_src !== 1'b0) begin
         n_bad++;
         $display("FAIL mr_outputs: got d=%h t=%h s=%b want 0000 0 0", res_data, res_tag, res_src);
      end
      n_total++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
         n_bad++; $display("FAIL mr_readys: got %b%b want 00", req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         n_total++;
         if (res_valid !== 1'b0) begin n_bad++; $display("FAIL mr_no_result%0d: got 1 want 0", i); end
      end
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      n_total++;
      if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
         n_bad++; $display("FAIL mr_first_grant: got %b%b want 10", req0_ready, req1_ready);
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_full_scale();
      test_zero_operand();
      test_req1_tag();
      test_back_to_back();
      test_backpressure();
      test_reset_midop();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/mul8_share_ctrl.md
Name: mul8_share_ctrl

Overview:
- Sequential 8x8 unsigned multiplier controller that time-multiplexes one 4x4 array multiplier core over four partial products.
- The partial products are b*d, a*d<<4, b*c<<4 and a*c<<8, where a/b are the high/low nibbles of operand A and c/d are the high/low nibbles of operand B.
- Shares the core between two requesters with round-robin arbitration.
- Returns a 16-bit product plus the requester's tag over a valid/ready result channel. Sits between client blocks and the existing 4x4 multiplier datapath.

Parameters:
- TAG_W, 4, width of the user tag carried from request to result (legal range 1-8).

Ports:
- clk  in  1  single clock, all state rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a  in  8  requester 0 operand A.
- req0_b  in  8  requester 0 operand B.
- req0_tag  in  TAG_W  requester 0 tag.
- req1_valid  in  1  requester 1 has an operation.
- req1_ready  out  1  requester 1 operation accepted this cycle.
- req1_a  in  8  requester 1 operand A.
- req1_b  in  8  requester 1 operand B.
- req1_tag  in  TAG_W  requester 1 tag.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  16  unsigned product A*B.
- res_tag  out  TAG_W  tag of the accepted request.
- res_src  out  1  index of the requester that owned the operation.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, acc=16'h0000, res_valid=0, res_data=0, res_tag=0, res_src=0, busy=0, both readys=0.
  - last_grant=1, so requester 0 wins the first contention.
  - Any in-flight operation is discarded; no result is produced for it.
- States and transitions:
  - IDLE -> P0 when any reqN_valid is high.
  - P0 -> P1 -> P2 -> P3 -> DONE, unconditionally, one cycle each.
  - DONE -> IDLE on res_valid & res_ready.
- Arbitration (IDLE only):
  - reqN_ready is combinational and high only in IDLE, for the granted requester.
  - Single valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - On acceptance: capture A, B, tag and src; update last_grant; clear acc to 0.
  - Ready is never asserted outside IDLE.
  - Requesters hold valid, operands and tag stable until ready; dropping valid before ready is permitted.
- Datapath sequencing:
  - One 4x4 core instance; its operand mux is selected by state.
  - P0: acc += {8'h00, b*d}.
  - P1: acc += (a*d)<<4.
  - P2: acc += (b*c)<<4.
  - P3: acc += (a*c)<<8.
  - Accumulator is 16 bits; the final sum never exceeds 16'hFE01, so no overflow is possible.
  - Intermediate adds are truncated to 16 bits.
- Latency and throughput:
  - Acceptance at edge T; res_valid rises after edge T+5 (five cycles).
  - res_data, res_tag and res_src are registered and held stable while res_valid=1 && res_ready=0.
  - res_valid falls on the edge after the handshake.
  - Minimum initiation interval is 6 cycles: accept, P0-P3, DONE. No overlap between operations.
- Boundary conditions:
  - res_ready high before DONE is ignored.
  - res_ready held permanently high gives DONE a duration of exactly 1 cycle.
  - A valid arriving during DONE waits for IDLE.
  - rst asserted in any state forces the reset values immediately, without waiting for a clock edge.
  - busy = (state != IDLE).

Optional Feature:
- Macro MUL8_ZERO_BYPASS_EN.
- Defined:
  - On acceptance, if A==0 or B==0, state goes directly IDLE->DONE with res_data=0.
  - res_valid rises after edge T+1 (one cycle).
  - Arbitration and last_grant update are unchanged.
- Not defined: zero operands take the full P0-P3 sequence, same as any other operands.

Test Plan:
- req0 A=8'hFF, B=8'hFF, res_ready=1 -> res_data=16'hFE01, res_src=0, res_valid rises after edge T+5.
- req1 A=8'h12, B=8'h34, tag=4'hA -> res_data=16'h03A8, res_tag=4'hA, res_src=1, req0_ready stays 0 throughout.
- Both requesters valid continuously (req0 7*9, req1 8'h80*8'h02) -> grants alternate 0,1,0,1; results 16'h003F and 16'h0100 in alternating order.
- Result for 8'h0F*8'h10 with res_ready low for 10 cycles -> res_valid and res_data=16'h00F0 held stable; busy=1; no new ready; IDLE follows the cycle after res_ready.
- rst pulsed during P2 of an operation -> all outputs at reset values immediately; no result emitted; next contention grants requester 0.
- A=8'h00, B=8'h5A -> res_data=0: at T+1 with MUL8_ZERO_BYPASS_EN defined, at T+5 without it.
